status_link_tx: RTL
===================

// Module: status_link_tx
// PURPOSE
//  Transmit side of the board-to-board battle link. Serialises the local game status code and
//  pending attack (garbage) lines into UART-style frames on one wire. The peer board's receiver
//  decodes these frames into its match_in/table inputs. Sits between game_status and the link pin.
// PARAMETERS
//  CLKS_PER_BIT    434       global_clk cycles per serial bit, >=2 (115200 baud @ 50 MHz)
//  HEARTBEAT_CLKS  5000000   idle cycles before an unsolicited keep-alive frame, >CLKS_PER_BIT*11
// PORTS
//  global_clk        in   1  system clock; all logic rising-edge
//  rst               in   1  asynchronous, active-high reset
//  stat_in           in   3  current status code (STAT_* encoding) from game_status
//  attack_lines_in   in   4  garbage lines to send to peer, 0..15
//  attack_valid_in   in   1  attack_lines_in valid
//  attack_ready_out  out  1  attack buffer free; transfer when valid&&ready on a clock edge
//  tx_out            out  1  serial line, idle high
//  busy_out          out  1  frame in flight (START..STOP)
//  done_out          out  1  one-cycle pulse on the last cycle of the stop bit
// BEHAVIOUR
//  Reset (async): tx_out=1, busy_out=0, done_out=0, attack_ready_out=1, state=IDLE, last_stat=0,
//   seq=0, attack buffer empty, heartbeat counter=0. Reset mid-frame aborts the frame; line goes high at once.
//  Frame: start bit 0, 8 payload bits LSB first, [parity], stop bit 1. Each bit exactly CLKS_PER_BIT cycles.
//  Payload: [2:0]=stat snapshot, [3]=seq toggle (flips every frame), [7:4]=attack lines (0 if none).
//  Triggers, evaluated in IDLE only: (a) stat_in != last_stat, (b) attack buffer full,
//   (c) heartbeat counter == HEARTBEAT_CLKS-1. Any trigger -> START on the next edge.
//  One frame carries everything pending: a status change and an attack coincide in one frame.
//  Snapshot: payload, last_stat<=stat_in, and attack buffer release happen on the IDLE->START edge;
//   status changes during the frame are caught by trigger (a) after STOP.
//  Attack handshake: 1-deep buffer. attack_ready_out = buffer empty. Accept allowed in any state,
//   including the cycle the buffer is released (ready is registered: 1 again the cycle after release).
//  Heartbeat counter: cleared on every IDLE->START, increments in IDLE, saturates at expiry value.
//  FSM: IDLE -> START -> DATA(8 bits, bit index 0..7) -> [PARITY] -> STOP -> IDLE.
//   STOP->IDLE takes no idle cycle if a trigger is already pending: next START begins on the following edge.
//  Latency: trigger edge to tx_out falling = 1 cycle; frame = 10*CLKS_PER_BIT cycles (11 with parity).
//  Counters: bit-period counter $clog2(CLKS_PER_BIT) bits, wraps at CLKS_PER_BIT-1; bit index 3 bits.
//  stat_in values 0..7 all legal; no filtering. attack_lines_in=0 is accepted and sent as 0.
// CONFIGURATION
//  LINK_PARITY_EN defined: even-parity bit over payload[7:0] after DATA; frame 11 bits.
//  Not defined: no PARITY state, frame 10 bits; receiver must be built with the same setting.
// STRUCTURE
//  Shared include game_defs.vh: STAT_* codes (3-bit), LINK_* payload field offsets, frame bit count.
//  Sub-module baud_tick_gen (CLKS_PER_BIT): bit-period counter, restart input, one-cycle tick output.
//  FSM, payload shift register, attack buffer, heartbeat counter stay in status_link_tx.
// TESTING (CLKS_PER_BIT=4, HEARTBEAT_CLKS=100)
//  1 Reset, stat_in held 000 -> tx_out=1 stays; first frame at cycle 100 (heartbeat), payload 0x00 (seq=0).
//  2 stat_in 000->110 -> tx_out low 1 cycle later, payload 0x06; 40 cycles later done_out pulses; next
//    heartbeat frame carries payload 0x0E (seq=1).
//  3 attack 4'd3 valid while stat changes to 101 same cycle -> single frame payload 0x35, ready low until release.
//  4 Two attacks (2 then 5) back-to-back during a busy frame -> 2 accepted, ready=0 holds 5; frames 0x2x then 0x5x
//    back-to-back with no idle cycle.
//  5 Assert rst at DATA bit 4 -> tx_out=1, busy_out=0 asynchronously; after release no frame until a trigger.
//  6 LINK_PARITY_EN, payload 0x07 -> parity bit 1, stop at bit 10, done_out at cycle 44 of frame.

Source files
------------

// File: rtl/status_link_tx_pkg.sv
// Shared definitions for the battle-link transmitter: status codes, payload layout, FSM states.
// Frame length depends on the LINK_PARITY_EN build macro.
package status_link_tx_pkg;

  localparam logic [2:0] STAT_IDLE    = 3'd0;
  localparam logic [2:0] STAT_PLAYING = 3'd1;
  localparam logic [2:0] STAT_PAUSED  = 3'd2;
  localparam logic [2:0] STAT_LOST    = 3'd3;
  localparam logic [2:0] STAT_WON     = 3'd4;

  localparam int LINK_STAT_LSB = 0;
  localparam int LINK_SEQ_BIT  = 3;
  localparam int LINK_ATK_LSB  = 4;

`ifdef LINK_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } link_state_t;

  function automatic logic [7:0] pack_payload(logic [2:0] stat, logic seq, logic [3:0] atk);
    logic [7:0] p;
    p = '0;
    p[LINK_STAT_LSB +: 3] = stat;
    p[LINK_SEQ_BIT]       = seq;
    p[LINK_ATK_LSB +: 4]  = atk;
    return p;
  endfunction

endpackage

// File: rtl/status_link_tx_baud_tick_gen.sv
// Bit-period counter: one-cycle tick on the last clock of every serial bit.
// Held at zero while restart is high so a frame always starts on a full bit period.
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic global_clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge global_clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = !restart && (cnt == LAST);

endmodule

// File: rtl/status_link_tx.sv
// Battle-link transmitter: sends status code, sequence toggle and pending attack lines as UART frames.
// Define LINK_PARITY_EN to append an even-parity bit after the data bits.
module status_link_tx
  import status_link_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT   = 434,
  parameter int HEARTBEAT_CLKS = 5000000
) (
  input  logic       global_clk,
  input  logic       rst,
  input  logic [2:0] stat_in,
  input  logic [3:0] attack_lines_in,
  input  logic       attack_valid_in,
  output logic       attack_ready_out,
  output logic       tx_out,
  output logic       busy_out,
  output logic       done_out
);

  localparam int HB_W = $clog2(HEARTBEAT_CLKS);
  localparam logic [HB_W-1:0] HB_LAST = HB_W'(HEARTBEAT_CLKS - 1);

  link_state_t     state, state_next;
  logic [2:0]      last_stat;
  logic            seq;
  logic            atk_full;
  logic [3:0]      atk_buf;
  logic [HB_W-1:0] hb_cnt;
  logic [7:0]      shift;
  logic [2:0]      bit_idx;
  logic            tick;
  logic            trigger;
  logic            launch;
  logic            atk_take;
  logic [3:0]      atk_send;
  logic [7:0]      payload;
`ifdef LINK_PARITY_EN
  logic            par_bit;
`endif

  baud_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .global_clk (global_clk),
    .rst        (rst),
    .restart    (state == S_IDLE),
    .tick       (tick)
  );

  assign trigger  = (stat_in != last_stat) || atk_full || (hb_cnt == HB_LAST);
  assign atk_take = attack_valid_in && !atk_full;
  // An attack arriving on the launch edge rides in the same frame instead of waiting for the next one.
  assign atk_send = atk_full ? atk_buf : (atk_take ? attack_lines_in : 4'd0);
  assign payload  = pack_payload(stat_in, seq, atk_send);

  always_comb begin
    state_next = state;
    launch     = 1'b0;
    tx_out     = 1'b1;
    case (state)
      S_IDLE: begin
        if (trigger) begin
          state_next = S_START;
          launch     = 1'b1;
        end
      end
      S_START: begin
        tx_out = 1'b0;
        if (tick) state_next = S_DATA;
      end
      S_DATA: begin
        tx_out = shift[0];
        if (tick && bit_idx == 3'd7) begin
`ifdef LINK_PARITY_EN
          state_next = S_PARITY;
`else
          state_next = S_STOP;
`endif
        end
      end
`ifdef LINK_PARITY_EN
      S_PARITY: begin
        tx_out = par_bit;
        if (tick) state_next = S_STOP;
      end
`endif
      S_STOP: begin
        // Pending work chains straight into the next start bit.
        if (tick) begin
          if (trigger) begin
            state_next = S_START;
            launch     = 1'b1;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge global_clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      last_stat <= 3'd0;
      seq       <= 1'b0;
      hb_cnt    <= '0;
      shift     <= 8'd0;
      bit_idx   <= 3'd0;
`ifdef LINK_PARITY_EN
      par_bit   <= 1'b0;
`endif
    end else begin
      state <= state_next;
      if (launch) begin
        shift     <= payload;
        last_stat <= stat_in;
        seq       <= ~seq;
        hb_cnt    <= '0;
`ifdef LINK_PARITY_EN
        par_bit   <= ^payload;
`endif
      end else begin
        if (state == S_DATA && tick) shift <= shift >> 1;
        if (state == S_IDLE && hb_cnt != HB_LAST) hb_cnt <= hb_cnt + 1'b1;
      end
      if (state != S_DATA) begin
        bit_idx <= 3'd0;
      end else if (tick) begin
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

  always_ff @(posedge global_clk or posedge rst) begin
    if (rst) begin
      atk_full <= 1'b0;
      atk_buf  <= 4'd0;
    end else if (launch) begin
      atk_full <= 1'b0;
    end else if (atk_take) begin
      atk_full <= 1'b1;
      atk_buf  <= attack_lines_in;
    end
  end

  assign attack_ready_out = !atk_full;
  assign busy_out         = (state != S_IDLE);
  assign done_out         = (state == S_STOP) && tick;

endmodule
